// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment scan decoder and the UART mirror path.
// Segment patterns are active-low a..g in bits 0..6; digit selects are active-low one-hot.
package fnd_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] COMM_D0 = 4'b1110;
    localparam logic [3:0] COMM_D1 = 4'b1101;
    localparam logic [3:0] COMM_D2 = 4'b1011;
    localparam logic [3:0] COMM_D3 = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_t;

    // True when exactly one digit select is driven low.
    function automatic logic comm_valid(input logic [3:0] comm);
        logic ok;
        case (comm)
            COMM_D0, COMM_D1, COMM_D2, COMM_D3: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fnd_scan_decoder_if.sv
// Multiplexed 7-segment bus as driven by the display controller.
// master = display controller, slave = passive observers such as the scan decoder.
interface fnd_scan_decoder_if;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;

    modport master (output fnd_comm, output fnd_font);
    modport slave  (input  fnd_comm, input  fnd_font);
endinterface

// File: rtl/seg_to_bcd.sv
// Combinational 7-segment to nibble lookup. Blank maps to F; unknown patterns
// drop valid and report F so the caller decides how to flag them.
module seg_to_bcd
    import fnd_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       valid
);

    // Pattern table lookup
    always_comb begin
        bcd   = 4'hF;
        valid = 1'b1;
        case (seg)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = 4'hF;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/fnd_scan_decoder.sv
// Passive observer of the multiplexed 7-segment bus: waits for each digit
// pattern to settle, decodes it, and publishes a full four-digit frame.
// Optional build macro FND_DECODE_ERR_EN: unknown patterns become nibble E and
// set the sticky seg_err; otherwise they read as F and seg_err is tied low.
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic                clk,
    input  logic                reset,
    fnd_scan_decoder_if.slave   fnd,
    output logic [15:0]         digits,
    output logic [3:0]          dots,
    output logic                frame_valid,
    output logic                frame_changed,
    output logic                scan_lost,
    output logic                seg_err
);

    localparam int SW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    s_comm, p_comm;
    logic [7:0]    s_font, p_font;
    logic [SW-1:0] stab_cnt, stab_nxt;
    logic [TW-1:0] to_cnt;
    scan_state_t   state, state_nxt;
    logic          change, comm_ok, capture;
    logic [1:0]    idx;
    logic [3:0]    lut_bcd, cap_nib;
    logic          lut_valid;
    logic [15:0]   shadow_digits;
    logic [3:0]    shadow_dots, seen_mask, mask_keep;
    logic          frame_full, lost_rise;

    seg_to_bcd u_seg (
        .seg   (s_font[6:0]),
        .bcd   (lut_bcd),
        .valid (lut_valid)
    );

    assign change     = {s_comm, s_font} != {p_comm, p_font};
    assign comm_ok    = comm_valid(s_comm);
    assign frame_full = seen_mask == 4'hF;
    assign lost_rise  = (to_cnt == TMO_MAX) && !scan_lost && !capture;
    assign mask_keep  = (frame_full || lost_rise) ? 4'h0 : seen_mask;

`ifdef FND_DECODE_ERR_EN
    assign cap_nib = lut_valid ? lut_bcd : 4'hE;
`else
    assign cap_nib = lut_valid ? lut_bcd : 4'hF;
`endif

    // Stability count of the next edge; a changed sample restarts it
    always_comb begin
        stab_nxt = stab_cnt;
        if (change)
            stab_nxt = '0;
        else if (stab_cnt != STAB_MAX)
            stab_nxt = stab_cnt + SW'(1);
    end

    // Capture slot decoded from the one-hot-low select
    always_comb begin
        idx = 2'd0;
        case (s_comm)
            COMM_D1: idx = 2'd1;
            COMM_D2: idx = 2'd2;
            COMM_D3: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    // Scan FSM next state; capture fires on the edge the count reaches its top
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE:
                if (comm_ok) state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (!comm_ok)
                    state_nxt = ST_IDLE;
                else if (!change && stab_nxt == STAB_MAX) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            ST_HOLD:
                if (change) state_nxt = comm_ok ? ST_SETTLE : ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // Input sample stage, previous sample, stability count and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_comm   <= 4'hF;
            s_font   <= 8'hFF;
            p_comm   <= 4'hF;
            p_font   <= 8'hFF;
            stab_cnt <= '0;
            state    <= ST_IDLE;
        end else begin
            s_comm   <= fnd.fnd_comm;
            s_font   <= fnd.fnd_font;
            p_comm   <= s_comm;
            p_font   <= s_font;
            stab_cnt <= stab_nxt;
            state    <= state_nxt;
        end
    end

    // Shadow frame assembly; mask drops on frame publish or on scan loss
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_digits <= 16'hFFFF;
            shadow_dots   <= 4'h0;
            seen_mask     <= 4'h0;
        end else begin
            if (capture) begin
                shadow_digits[{idx, 2'b00} +: 4] <= cap_nib;
                shadow_dots[idx]                 <= ~s_font[7];
            end
            seen_mask <= mask_keep | (capture ? (4'b0001 << idx) : 4'h0);
        end
    end

    // Publish a completed frame one edge after the final capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits        <= 16'hFFFF;
            dots          <= 4'h0;
            frame_valid   <= 1'b0;
            frame_changed <= 1'b0;
        end else begin
            frame_valid   <= frame_full;
            frame_changed <= frame_full && ({shadow_digits, shadow_dots} != {digits, dots});
            if (frame_full) begin
                digits <= shadow_digits;
                dots   <= shadow_dots;
            end
        end
    end

    // Capture watchdog; a capture in the same cycle as expiry takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt    <= '0;
            scan_lost <= 1'b0;
        end else if (capture) begin
            to_cnt    <= '0;
            scan_lost <= 1'b0;
        end else if (to_cnt == TMO_MAX) begin
            scan_lost <= 1'b1;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

`ifdef FND_DECODE_ERR_EN
    // Sticky flag for any undecodable pattern that was captured
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            seg_err <= 1'b0;
        else if (capture && !lut_valid)
            seg_err <= 1'b1;
    end
`else
    assign seg_err = 1'b0;
`endif

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Self-checking bench for fnd_scan_decoder: directed scenarios plus randomized
// segment sequences checked against a frame-level reference model.
// Honours FND_DECODE_ERR_EN for the expected error nibble and seg_err.
module tb_fnd_scan_decoder;

    localparam int STABLE = 16;
    localparam int TMO    = 300;
`ifdef FND_DECODE_ERR_EN
    localparam logic [3:0] ERR_NIB = 4'hE;
    localparam logic       ERR_EN  = 1'b1;
`else
    localparam logic [3:0] ERR_NIB = 4'hF;
    localparam logic       ERR_EN  = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic        frame_valid, frame_changed, scan_lost, seg_err;

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .reset         (reset),
        .fnd           (bus),
        .digits        (digits),
        .dots          (dots),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .scan_lost     (scan_lost),
        .seg_err       (seg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frames reported by the DUT
    logic [15:0] obs_d[$];
    logic [3:0]  obs_p[$];
    logic        obs_c[$];

    always @(negedge clk) begin
        if (!reset && frame_valid) begin
            obs_d.push_back(digits);
            obs_p.push_back(dots);
            obs_c.push_back(frame_changed);
        end
    end

    // Reference model state
    logic [6:0]  font_tab [10];
    logic [3:0]  comm_tab [4];
    logic [3:0]  m_nib [4];
    logic        m_dot [4];
    logic [3:0]  m_mask;
    logic [15:0] m_digits;
    logic [3:0]  m_dots;
    logic        m_err;
    logic [11:0] m_last;
    logic [15:0] exp_d[$];
    logic [3:0]  exp_p[$];
    logic        exp_c[$];

    function automatic int pos_of(input logic [3:0] c);
        for (int k = 0; k < 4; k++)
            if (c == ~(4'b0001 << k)) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_nib[k] = 4'hF;
            m_dot[k] = 1'b0;
        end
        m_mask   = 4'h0;
        m_digits = 16'hFFFF;
        m_dots   = 4'h0;
        m_err    = 1'b0;
        m_last   = 12'hFFF;
    endtask

    task automatic clear_queues();
        obs_d.delete(); obs_p.delete(); obs_c.delete();
        exp_d.delete(); exp_p.delete(); exp_c.delete();
    endtask

    // Drive one bus pattern for n cycles and predict its effect: it is captured
    // only when the select is valid, it is new, and it lasts STABLE cycles.
    task automatic seg(input logic [3:0] c, input logic [7:0] f, input int n);
        int          p;
        logic [3:0]  nib;
        logic        found;
        logic [15:0] fd;
        logic [3:0]  fp;
        bus.fnd_comm = c;
        bus.fnd_font = f;
        p = pos_of(c);
        if (p >= 0 && n >= STABLE && {c, f} != m_last) begin
            found = 1'b0;
            nib   = 4'hF;
            if (f[6:0] == 7'h7F) found = 1'b1;
            for (int k = 0; k < 10; k++)
                if (font_tab[k] == f[6:0]) begin
                    nib   = 4'(k);
                    found = 1'b1;
                end
            if (!found) begin
                nib = ERR_NIB;
                if (ERR_EN) m_err = 1'b1;
            end
            m_nib[p]  = nib;
            m_dot[p]  = ~f[7];
            m_mask[p] = 1'b1;
            if (m_mask == 4'hF) begin
                fd = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                fp = {m_dot[3], m_dot[2], m_dot[1], m_dot[0]};
                exp_d.push_back(fd);
                exp_p.push_back(fp);
                exp_c.push_back({fd, fp} != {m_digits, m_dots});
                m_digits = fd;
                m_dots   = fp;
                m_mask   = 4'h0;
            end
        end
        m_last = {c, f};
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (digits !== 16'hFFFF) begin errors++; $display("FAIL reset_digits got %h want ffff", digits); end
        checks++; if (dots !== 4'h0) begin errors++; $display("FAIL reset_dots got %b want 0000", dots); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got %b want 0", frame_valid); end
        checks++; if (frame_changed !== 1'b0) begin errors++; $display("FAIL reset_frame_changed got %b want 0", frame_changed); end
        checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL reset_scan_lost got %b want 0", scan_lost); end
        checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL reset_seg_err got %b want 0", seg_err); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_partial();
        clear_queues();
        seg(4'b1110, 8'hC0, 20);
        repeat (2) @(negedge clk);
        checks++; if (obs_d.size() !== 0) begin errors++; $display("FAIL partial_frames got %0d want 0", obs_d.size()); end
        checks++; if (dut.seen_mask !== 4'b0001) begin errors++; $display("FAIL partial_mask got %b want 0001", dut.seen_mask); end
        checks++; if (digits !== 16'hFFFF || dots !== 4'h0) begin errors++; $display("FAIL partial_outputs got %h/%b want ffff/0000", digits, dots); end
    endtask

    task automatic test_frame();
        clear_queues();
        seg(4'b1110, 8'h92, 20);
        seg(4'b1101, 8'hF9, 20);
        seg(4'b1011, 8'h30, 20);
        seg(4'b0111, 8'hA4, 20);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_d.size() !== 1) begin errors++; $display("FAIL frame_count got %0d want 1", obs_d.size()); end
        else begin
            checks++; if (obs_d[0] !== 16'h2315) begin errors++; $display("FAIL frame_digits got %h want 2315", obs_d[0]); end
            checks++; if (obs_p[0] !== 4'b0100) begin errors++; $display("FAIL frame_dots got %b want 0100", obs_p[0]); end
            checks++; if (obs_c[0] !== 1'b1) begin errors++; $display("FAIL frame_changed got %b want 1", obs_c[0]); end
        end
    endtask

    task automatic test_repeat();
        clear_queues();
        seg(4'b1110, 8'h92, 20);
        seg(4'b1101, 8'hF9, 20);
        seg(4'b1011, 8'h30, 20);
        seg(4'b0111, 8'hA4, 20);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_d.size() !== 1) begin errors++; $display("FAIL repeat_count got %0d want 1", obs_d.size()); end
        else begin
            checks++; if (obs_c[0] !== 1'b0) begin errors++; $display("FAIL repeat_changed got %b want 0", obs_c[0]); end
            checks++; if (obs_d[0] !== 16'h2315) begin errors++; $display("FAIL repeat_digits got %h want 2315", obs_d[0]); end
        end
    endtask

    task automatic test_glitch();
        clear_queues();
        seg(4'b1101, 8'h80, 5);
        seg(4'b1101, 8'hC0, 20);
        seg(4'b1011, 8'h30, 20);
        seg(4'b0111, 8'hA4, 20);
        seg(4'b1110, 8'h92, 20);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_d.size() !== 1) begin errors++; $display("FAIL glitch_count got %0d want 1", obs_d.size()); end
        else begin
            checks++; if (obs_d[0] !== 16'h2305) begin errors++; $display("FAIL glitch_digits got %h want 2305", obs_d[0]); end
            checks++; if (obs_c[0] !== 1'b1) begin errors++; $display("FAIL glitch_changed got %b want 1", obs_c[0]); end
        end
    endtask

    task automatic test_blank_err();
        clear_queues();
        for (int k = 0; k < 4; k++) seg(comm_tab[k], 8'hFF, 20);
        repeat (2) @(negedge clk);
        checks++; if (digits !== 16'hFFFF || dots !== 4'h0) begin errors++; $display("FAIL blank_frame got %h/%b want ffff/0000", digits, dots); end
        checks++; if (seg_err !== 1'b0) begin errors++; $display("FAIL blank_seg_err got %b want 0", seg_err); end
        for (int k = 0; k < 3; k++) seg(comm_tab[k], 8'hFF, 20);
        seg(4'b0111, 8'h55, 20);
        repeat (2) @(negedge clk);
        checks++; if (digits !== {ERR_NIB, 12'hFFF}) begin errors++; $display("FAIL bad_pattern_digits got %h want %h", digits, {ERR_NIB, 12'hFFF}); end
        checks++; if (dots !== 4'b1000) begin errors++; $display("FAIL bad_pattern_dots got %b want 1000", dots); end
        checks++; if (seg_err !== ERR_EN) begin errors++; $display("FAIL bad_pattern_seg_err got %b want %b", seg_err, ERR_EN); end
        checks++; if (obs_d.size() !== 2) begin errors++; $display("FAIL blank_err_count got %0d want 2", obs_d.size()); end
    endtask

    task automatic test_random();
        logic [3:0] c;
        logic [7:0] f;
        int         n;
        clear_queues();
        for (int i = 0; i < 60; i++) begin
            do begin
                if (i % 4 == 0 || $urandom_range(0, 9) < 7) c = comm_tab[$urandom_range(0, 3)];
                else c = $urandom_range(0, 1) ? 4'hF : 4'hC;
                case ($urandom_range(0, 3))
                    0, 1:    f = {1'($urandom_range(0, 1)), font_tab[$urandom_range(0, 9)]};
                    2:       f = {1'($urandom_range(0, 1)), 7'h7F};
                    default: f = 8'($urandom);
                endcase
            end while ({c, f} == m_last);
            n = (i % 4 == 0) ? $urandom_range(STABLE, 25) : $urandom_range(3, 25);
            seg(c, f, n);
        end
        seg(4'hF, 8'hFF, 4);
        checks++;
        if (obs_d.size() !== exp_d.size()) begin
            errors++; $display("FAIL random_count got %0d want %0d", obs_d.size(), exp_d.size());
        end else begin
            foreach (exp_d[i]) begin
                checks++;
                if (obs_d[i] !== exp_d[i] || obs_p[i] !== exp_p[i] || obs_c[i] !== exp_c[i]) begin
                    errors++;
                    $display("FAIL random_frame[%0d] got %h/%b/%b want %h/%b/%b", i,
                             obs_d[i], obs_p[i], obs_c[i], exp_d[i], exp_p[i], exp_c[i]);
                end
            end
        end
        checks++; if (dut.seen_mask !== m_mask) begin errors++; $display("FAIL random_mask got %b want %b", dut.seen_mask, m_mask); end
        checks++; if (seg_err !== m_err) begin errors++; $display("FAIL random_seg_err got %b want %b", seg_err, m_err); end
        checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL random_scan_lost got %b want 0", scan_lost); end
    endtask

    task automatic test_timeout();
        clear_queues();
        seg(4'b1110, 8'hC0, 20);
        seg(4'hF, 8'hFF, 200);
        checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", scan_lost); end
        seg(4'hF, 8'hFF, 150);
        m_mask = 4'h0;
        checks++; if (scan_lost !== 1'b1) begin errors++; $display("FAIL timeout_lost got %b want 1", scan_lost); end
        checks++; if (digits !== m_digits || dots !== m_dots) begin errors++; $display("FAIL timeout_hold got %h/%b want %h/%b", digits, dots, m_digits, m_dots); end
        checks++; if (dut.seen_mask !== 4'h0) begin errors++; $display("FAIL timeout_mask got %b want 0000", dut.seen_mask); end
        seg(4'b1101, 8'hF9, 20);
        checks++; if (scan_lost !== 1'b0) begin errors++; $display("FAIL timeout_recover got %b want 0", scan_lost); end
        checks++; if (dut.seen_mask !== m_mask) begin errors++; $display("FAIL timeout_recover_mask got %b want %b", dut.seen_mask, m_mask); end
    endtask

    task automatic test_reset_mid();
        clear_queues();
        seg(4'b1110, 8'h92, 20);
        seg(4'b1101, 8'hF9, 20);
        seg(4'b1011, 8'h30, 20);
        seg(4'b0111, 8'hA4, 20);
        seg(4'b1011, 8'hB0, 20);
        checks++; if (digits !== 16'h2315) begin errors++; $display("FAIL premid_digits got %h want 2315", digits); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (digits !== 16'hFFFF || dots !== 4'h0) begin errors++; $display("FAIL midreset_outputs got %h/%b want ffff/0000", digits, dots); end
        checks++; if (frame_valid !== 1'b0 || frame_changed !== 1'b0) begin errors++; $display("FAIL midreset_pulses got %b%b want 00", frame_valid, frame_changed); end
        checks++; if (scan_lost !== 1'b0 || seg_err !== 1'b0) begin errors++; $display("FAIL midreset_flags got %b%b want 00", scan_lost, seg_err); end
        checks++; if (dut.seen_mask !== 4'h0) begin errors++; $display("FAIL midreset_mask got %b want 0000", dut.seen_mask); end
        bus.fnd_comm = 4'hF;
        bus.fnd_font = 8'hFF;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        font_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        comm_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bus.fnd_comm = 4'hF;
        bus.fnd_font = 8'hFF;
        reset = 1'b1;
        model_reset();
        test_reset();
        test_partial();
        test_frame();
        test_repeat();
        test_glitch();
        test_blank_err();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
